// File: rtl/bg_scroll_gen.sv
// bg_scroll_gen: scroll-position generator for the background tile layer.
// CPU writes land in shadow scroll registers. The shadows are copied to the
// active registers at frame start. HPIXSCRL counts per pixel from the scrolled
// start value, and VPIXSCRL is fixed for the whole line.
// Optional feature: define BG_SCROLL_LINE_LATCH_EN to also commit the shadows
// at every hblank rising edge (per-line raster scroll).
module bg_scroll_gen #(
    parameter logic [8:0] H_PRELOAD = 9'd8,
    parameter logic [7:0] V_OFFSET  = 8'd0
) (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       pixel_ce,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [7:0] vcount,
    input  logic       SCREEN_FLIP,
    input  logic       SCRLX_LO_CS,
    input  logic       SCRLX_HI_CS,
    input  logic       SCRLY_CS,
    input  logic       Z80_WR,
    input  logic [7:0] CPU_DIN,
    output logic [8:0] HPIXSCRL,
    output logic [7:0] VPIXSCRL,
    output logic       scroll_commit
);

    // Starting horizontal position for a line. A flipped screen counts down
    // from the bitwise complement of the preloaded scroll value.
    function automatic logic [8:0] start_h(input logic [8:0] x, input logic flip);
        logic [8:0] s;
        s = x + H_PRELOAD;
        return flip ? ~s : s;
    endfunction

    // Vertical position for a line. A flipped screen mirrors the raw line count.
    function automatic logic [7:0] start_v(input logic [7:0] vc, input logic [7:0] y,
                                           input logic flip);
        logic [7:0] line;
        line = flip ? ~vc : vc;
        return line + V_OFFSET + y;
    endfunction

    logic       wr_x_lo_n, wr_x_hi_n, wr_y_n;
    logic       wr_x_lo_q, wr_x_hi_q, wr_y_q;
    logic       wr_x_lo, wr_x_hi, wr_y;
    logic       vblank_q;
    logic       commit;
    logic [8:0] shadow_x, active_x;
    logic [7:0] shadow_y, active_y;
    logic       hblank_pix_q;
    logic       line_active;
    logic       flip_line;
    logic       line_start;

    assign wr_x_lo_n = SCRLX_LO_CS | Z80_WR;
    assign wr_x_hi_n = SCRLX_HI_CS | Z80_WR;
    assign wr_y_n    = SCRLY_CS | Z80_WR;

    // A write fires once, on the falling edge of each strobe.
    assign wr_x_lo = wr_x_lo_q & ~wr_x_lo_n;
    assign wr_x_hi = wr_x_hi_q & ~wr_x_hi_n;
    assign wr_y    = wr_y_q & ~wr_y_n;

    // Write strobe history. It resets to the idle (high) level so that a strobe
    // already held low when reset is released does not produce a write.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            wr_x_lo_q <= 1'b1;
            wr_x_hi_q <= 1'b1;
            wr_y_q    <= 1'b1;
        end else begin
            wr_x_lo_q <= wr_x_lo_n;
            wr_x_hi_q <= wr_x_hi_n;
            wr_y_q    <= wr_y_n;
        end
    end

    // vblank history, used for rising-edge detection
    always_ff @(posedge master_clk) begin
        if (reset) vblank_q <= 1'b0;
        else       vblank_q <= vblank;
    end

`ifdef BG_SCROLL_LINE_LATCH_EN
    logic hblank_q;

    // hblank history, used for per-line commit edge detection
    always_ff @(posedge master_clk) begin
        if (reset) hblank_q <= 1'b0;
        else       hblank_q <= hblank;
    end

    assign commit = (vblank & ~vblank_q) | (hblank & ~hblank_q);
`else
    assign commit = vblank & ~vblank_q;
`endif

    // Shadow and active scroll registers. A write in the same cycle as a commit
    // updates only the shadow, so the active value is the shadow from before the write.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            shadow_x      <= 9'd0;
            shadow_y      <= 8'd0;
            active_x      <= 9'd0;
            active_y      <= 8'd0;
            scroll_commit <= 1'b0;
        end else begin
            if (wr_x_lo) shadow_x[7:0] <= CPU_DIN;
            if (wr_x_hi) shadow_x[8]   <= CPU_DIN[0];
            if (wr_y)    shadow_y      <= CPU_DIN;
            if (commit) begin
                active_x <= shadow_x;
                active_y <= shadow_y;
            end
            scroll_commit <= commit;
        end
    end

    // Line start is the first pixel with hblank low after a pixel with hblank high.
    assign line_start = pixel_ce & ~hblank & hblank_pix_q;

    // Scrolled position counters. They advance only on pixel_ce. After a reset
    // they stay at 0 until a line start has been seen.
    always_ff @(posedge master_clk) begin
        if (reset) begin
            hblank_pix_q <= 1'b0;
            line_active  <= 1'b0;
            flip_line    <= 1'b0;
            HPIXSCRL     <= 9'd0;
            VPIXSCRL     <= 8'd0;
        end else if (pixel_ce) begin
            hblank_pix_q <= hblank;
            if (line_start) begin
                HPIXSCRL    <= start_h(active_x, SCREEN_FLIP);
                VPIXSCRL    <= start_v(vcount, active_y, SCREEN_FLIP);
                flip_line   <= SCREEN_FLIP;
                line_active <= 1'b1;
            end else if (!hblank && line_active) begin
                HPIXSCRL <= flip_line ? (HPIXSCRL - 9'd1) : (HPIXSCRL + 9'd1);
            end
        end
    end

endmodule
